// File: rtl/npu_out_quant.sv
// Output stage of the 3x3 systolic NPU: removes column skew, requantizes each
// column to int8 and buffers packed 24-bit words in a first-word-fall-through FIFO.
module npu_out_quant #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [2:0]    in_valid,
    input  logic [15:0]   in_col0,
    input  logic [15:0]   in_col1,
    input  logic [15:0]   in_col2,
    input  logic [3:0]    cfg_shift,
    input  logic          cfg_relu,
    input  logic          clr,
    input  logic          rd_en,
    output logic [23:0]   rd_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level,
    output logic          ovf,
    output logic          align_err
);
    localparam int PW = $clog2(DEPTH);

    // Handshake: a word is pushed on any edge where q_valid_q is high and a slot
    // is free (or being freed by a same-edge pop); a pop happens on any edge where
    // rd_en is high and the FIFO is non-empty. There is no backpressure upstream.

    logic [15:0]   c0_d1_q, c0_d2_q, c1_d1_q;
    logic          v0_d1_q, v0_d2_q, v1_d1_q;
    logic [23:0]   q_word_q, q_word_d;
    logic          q_valid_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          ovf_q, ovf_d, aerr_q, aerr_d;
    logic [23:0]   mem [DEPTH];

    logic flush, aligned_any, aligned_valid, pop, push_ok;

    // Floor shift, optional ReLU, then saturate to the int8 range.
    function automatic logic [7:0] quant(input logic [15:0] col,
                                         input logic [3:0]  sh,
                                         input logic        relu);
        logic signed [15:0] x;
        logic [7:0]         r;
        x = $signed(col) >>> sh;
        if (relu && (x < 16'sd0)) begin
            x = 16'sd0;
        end
        if (x > 16'sd127) begin
            r = 8'h7F;
        end else if (x < -16'sd128) begin
            r = 8'h80;
        end else begin
            r = x[7:0];
        end
        return r;
    endfunction

    assign flush = wb_rst_i | clr;

    always_comb begin
        aligned_any   = v0_d2_q | v1_d1_q | in_valid[2];
        aligned_valid = v0_d2_q & v1_d1_q & in_valid[2];
        q_word_d      = q_word_q;
        if (aligned_valid) begin
            q_word_d = {quant(in_col2, cfg_shift, cfg_relu),
                        quant(c1_d1_q, cfg_shift, cfg_relu),
                        quant(c0_d2_q, cfg_shift, cfg_relu)};
        end

        pop      = rd_en & ~empty_q;
        // A pop in the same edge frees the slot the push needs.
        push_ok  = q_valid_q & (~full_q | pop);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push_ok) - LW'(pop);
        empty_d  = (level_d == '0);
        full_d   = (level_d == LW'(DEPTH));
        ovf_d    = ovf_q | (q_valid_q & full_q & ~pop);
        aerr_d   = aerr_q | (aligned_any & ~aligned_valid);
    end

    always_ff @(posedge wb_clk_i) begin
        if (flush) begin
            c0_d1_q   <= '0;
            c0_d2_q   <= '0;
            c1_d1_q   <= '0;
            v0_d1_q   <= 1'b0;
            v0_d2_q   <= 1'b0;
            v1_d1_q   <= 1'b0;
            q_word_q  <= '0;
            q_valid_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            c0_d1_q   <= in_col0;
            c0_d2_q   <= c0_d1_q;
            c1_d1_q   <= in_col1;
            v0_d1_q   <= in_valid[0];
            v0_d2_q   <= v0_d1_q;
            v1_d1_q   <= in_valid[1];
            q_word_q  <= q_word_d;
            q_valid_q <= aligned_valid;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
        end
    end

    // Storage needs no reset: rd_data is gated to zero whenever the FIFO is empty.
    always_ff @(posedge wb_clk_i) begin
        if (!flush && push_ok) begin
            mem[wr_ptr_q] <= q_word_q;
        end
    end

    assign rd_data   = empty_q ? 24'h0 : mem[rd_ptr_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign align_err = aerr_q;

endmodule

// File: tb/tb_npu_out_quant.sv
// Directed bench for npu_out_quant: a cycle-history model with a word queue is
// compared every cycle, and hand-computed literals pin the key results.
module tb_npu_out_quant;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          wb_rst_i, clr, rd_en, cfg_relu;
    logic [2:0]    in_valid;
    logic [15:0]   in_col0, in_col1, in_col2;
    logic [3:0]    cfg_shift;
    logic [23:0]   rd_data;
    logic          empty, full, ovf, align_err;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    npu_out_quant #(.DEPTH(DEPTH), .LW(LW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .in_col0  (in_col0),
        .in_col1  (in_col1),
        .in_col2  (in_col2),
        .cfg_shift(cfg_shift),
        .cfg_relu (cfg_relu),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .ovf      (ovf),
        .align_err(align_err)
    );

    int total  = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] exp_q[$];
    bit          ovf_m, aerr_m, pend_v;
    logic [23:0] pend_w;
    int          cyc = 8;
    int          flush_cyc = 0;
    logic [2:0]  hv[256];
    logic [15:0] h0[256];
    logic [15:0] h1[256];

    // Floor division by 2^sh, then ReLU and int8 clamp, in plain integer arithmetic.
    function automatic logic [7:0] qbyte(input logic [15:0] col, input int sh, input bit relu);
        int x, d;
        x = int'($signed(col));
        d = 1 << sh;
        if (x >= 0) x = x / d;
        else x = -((-x + d - 1) / d);
        if (relu && x < 0) x = 0;
        if (x > 127) x = 127;
        if (x < -128) x = -128;
        return x[7:0];
    endfunction

    always @(posedge clk) begin : model
        bit a0, a1, a2, pop, acc;
        int i0, i1;
        hv[cyc % 256] = in_valid;
        h0[cyc % 256] = in_col0;
        h1[cyc % 256] = in_col1;
        if (wb_rst_i || clr) begin
            exp_q.delete();
            ovf_m     = 1'b0;
            aerr_m    = 1'b0;
            pend_v    = 1'b0;
            flush_cyc = cyc;
        end else begin
            i0  = (cyc - 2) % 256;
            i1  = (cyc - 1) % 256;
            a0  = (cyc - 2 > flush_cyc) && (hv[i0][0] === 1'b1);
            a1  = (cyc - 1 > flush_cyc) && (hv[i1][1] === 1'b1);
            a2  = (in_valid[2] === 1'b1);
            pop = (rd_en === 1'b1) && (exp_q.size() > 0);
            acc = pend_v && (exp_q.size() < DEPTH || pop);
            if (pend_v && !acc) ovf_m = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(pend_w);
            if (a0 && a1 && a2) begin
                pend_v = 1'b1;
                pend_w = {qbyte(in_col2, int'(cfg_shift), cfg_relu),
                          qbyte(h1[i1], int'(cfg_shift), cfg_relu),
                          qbyte(h0[i0], int'(cfg_shift), cfg_relu)};
            end else begin
                pend_v = 1'b0;
                if (a0 || a1 || a2) aerr_m = 1'b1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_level", 32'(level), 32'(exp_q.size()));
            check("cmp_empty", 32'(empty), 32'(exp_q.size() == 0));
            check("cmp_full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("cmp_rd_data", 32'(rd_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
            check("cmp_ovf", 32'(ovf), 32'(ovf_m));
            check("cmp_align_err", 32'(align_err), 32'(aerr_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2);
        in_valid = v;
        in_col0  = c0;
        in_col1  = c1;
        in_col2  = c2;
        step();
    endtask

    task automatic idle_inputs();
        in_valid = 3'b000;
        in_col0  = '0;
        in_col1  = '0;
        in_col2  = '0;
    endtask

    // One row vector with natural systolic skew; leaves inputs idle afterwards.
    task automatic send_vec(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        drive(3'b001, c0, '0, '0);
        drive(3'b010, '0, c1, '0);
        drive(3'b100, '0, '0, c2);
        idle_inputs();
    endtask

    function automatic logic [15:0] vcol(input int i, input int j);
        return 16'(i + 1 + 16 * j);
    endfunction

    // Back-to-back skewed vectors first..first+n-1, stopping early after 'cut' cycles.
    task automatic stream(input int n, input int first, input int cut);
        for (int k = 0; k < n + 2 && k < cut; k++) begin
            in_valid[0] = (k < n);
            in_col0     = (k < n) ? vcol(first + k, 0) : 16'h0;
            in_valid[1] = (k >= 1 && k - 1 < n);
            in_col1     = (k >= 1 && k - 1 < n) ? vcol(first + k - 1, 1) : 16'h0;
            in_valid[2] = (k >= 2 && k - 2 < n);
            in_col2     = (k >= 2 && k - 2 < n) ? vcol(first + k - 2, 2) : 16'h0;
            step();
        end
        idle_inputs();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            hv[i] = '0;
            h0[i] = '0;
            h1[i] = '0;
        end
        wb_rst_i  = 1'b1;
        clr       = 1'b0;
        rd_en     = 1'b0;
        cfg_shift = 4'd0;
        cfg_relu  = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_align_err", 32'(align_err), 32'h0);
        wb_rst_i = 1'b0;
        chk_en   = 1'b1;

        // Skewed single vector, shift 2
        cfg_shift = 4'd2;
        send_vec(16'h0140, 16'hFF00, 16'h1000);
        step();
        check("vec_empty", 32'(empty), 32'h0);
        check("vec_level", 32'(level), 32'h1);
        check("vec_rd_data", 32'(rd_data), 32'h7FC050);
        pop_n(1);
        check("pop1_empty", 32'(empty), 32'h1);

        // Same vector with ReLU
        cfg_relu = 1'b1;
        send_vec(16'h0140, 16'hFF00, 16'h1000);
        step();
        check("relu_rd_data", 32'(rd_data), 32'h7F0050);
        pop_n(1);
        check("relu_pop_empty", 32'(empty), 32'h1);
        check("relu_pop_rd_data", 32'(rd_data), 32'h0);
        cfg_relu = 1'b0;

        // Unskewed set: every stage sees a partial set
        drive(3'b111, 16'h0001, 16'h0002, 16'h0003);
        idle_inputs();
        repeat (3) step();
        check("misalign_err", 32'(align_err), 32'h1);
        check("misalign_level", 32'(level), 32'h0);
        repeat (3) step();
        check("misalign_sticky", 32'(align_err), 32'h1);
        pulse_clr();
        check("clr_align_err", 32'(align_err), 32'h0);

        // Overflow: nine vectors, no pops, shift 0
        cfg_shift = 4'd0;
        stream(9, 0, 100);
        step();
        check("ovf_level", 32'(level), 32'h8);
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_flag", 32'(ovf), 32'h1);
        check("ovf_head", 32'(rd_data), 32'h211101);

        // Full FIFO, push with simultaneous pop
        pulse_clr();
        stream(8, 0, 100);
        step();
        check("fill_full", 32'(full), 32'h1);
        check("fill_level", 32'(level), 32'h8);
        check("fill_ovf", 32'(ovf), 32'h0);
        send_vec(vcol(8, 0), vcol(8, 1), vcol(8, 2));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pushpop_level", 32'(level), 32'h8);
        check("pushpop_ovf", 32'(ovf), 32'h0);
        check("pushpop_head", 32'(rd_data), 32'h221202);
        pop_n(7);
        check("pushpop_tail", 32'(rd_data), 32'h291909);
        check("pushpop_tail_level", 32'(level), 32'h1);
        pop_n(1);

        // Saturation corners
        pulse_clr();
        send_vec(16'h7FFF, 16'h8000, 16'h007F);
        step();
        check("sat_corners", 32'(rd_data), 32'h7F807F);
        cfg_shift = 4'd15;
        send_vec(16'h8000, 16'h0000, 16'h0000);
        step();
        check("sat_level", 32'(level), 32'h2);
        pop_n(1);
        check("shift15_byte", 32'(rd_data[7:0]), 32'hFF);
        check("shift15_word", 32'(rd_data), 32'h0000FF);

        // Reset in the middle of a stream
        cfg_shift = 4'd0;
        stream(4, 3, 4);
        wb_rst_i = 1'b1;
        step();
        check("midrst_rd_data", 32'(rd_data), 32'h0);
        check("midrst_empty", 32'(empty), 32'h1);
        check("midrst_full", 32'(full), 32'h0);
        check("midrst_level", 32'(level), 32'h0);
        check("midrst_ovf", 32'(ovf), 32'h0);
        check("midrst_align_err", 32'(align_err), 32'h0);
        wb_rst_i = 1'b0;
        repeat (4) step();
        check("postrst_level", 32'(level), 32'h0);
        check("postrst_align_err", 32'(align_err), 32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/npu_out_quant.md
Name: npu_out_quant

Overview:
- Downstream stage of the 3x3 systolic NPU array. Consumes the three 16-bit column outputs.
- Removes the per-column systolic skew, requantizes each column to signed 8-bit (arithmetic shift, optional ReLU, saturation) and packs the three bytes into one 24-bit word.
- Words are buffered in a first-word-fall-through FIFO that the Wishbone read path pops.

Parameters:
- DEPTH, 8, FIFO depth in 24-bit words. Power of two, at least 2.
- LW, $clog2(DEPTH)+1, width of the level output.

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- in_valid  in  3  per-column valid; bit j qualifies in_colj
- in_col0  in  16  column 0 result, signed two's complement
- in_col1  in  16  column 1 result, signed
- in_col2  in  16  column 2 result, signed
- cfg_shift  in  4  arithmetic right-shift amount, 0..15
- cfg_relu  in  1  1 = clamp negative results to 0
- clr  in  1  synchronous flush: empties FIFO, clears flags and deskew pipe
- rd_en  in  1  pop request; ignored when empty
- rd_data  out  24  head word; [7:0]=col0, [15:8]=col1, [23:16]=col2
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  LW  number of words held, 0..DEPTH
- ovf  out  1  sticky: a word was dropped because the FIFO was full
- align_err  out  1  sticky: partial column set seen after deskew

Behaviour:
- Reset (wb_rst_i=1) and clr=1 have identical effect. They clear pointers, level=0, empty=1, full=0, ovf=0, align_err=0, rd_data=0, and all deskew/quant valids. wb_rst_i has priority over every other input. clr in the same cycle as a push or pop wins; the push or pop is discarded.
- Deskew: column j emerges j cycles after column 0 for the same row vector.
  - col0 and in_valid[0] are delayed 2 registers; col1 and in_valid[1] are delayed 1; col2 is not delayed.
  - aligned_valid = v0_d2 & v1_d1 & in_valid[2].
  - If any of the three aligned valids is set but not all, set align_err and drop that set. No word is produced.
- Quant stage (one register, loaded when aligned_valid):
  - x = sign-extended column >>> cfg_shift (floor; no rounding).
  - If cfg_relu and x<0, then x=0.
  - Saturate to [-128,127].
  - cfg_shift and cfg_relu are sampled in the aligned_valid cycle.
  - The register's valid bit q_valid follows aligned_valid one cycle later.
- FIFO push: q_valid pushes the packed word at the next edge. Latency from the aligned cycle (in_valid[2] high) is 2 edges until empty=0 and rd_data holds the word.
- FIFO pop: rd_data is always mem[rd_ptr], first-word-fall-through. rd_en & !empty advances rd_ptr at the edge. rd_data is 0 when empty.
- Simultaneous push and pop:
  - Both happen and level is unchanged.
  - When full, the pop frees a slot in the same edge, so the push is accepted and ovf is not set.
  - When empty, only the push occurs; the pop is ignored.
- Push while full without a pop: the word is dropped, ovf sets and stays set until reset or clr. FIFO contents are unchanged.
- Pointers wrap modulo DEPTH. full = (level==DEPTH), empty = (level==0). Both are registered, consistent with level.
- Back-to-back aligned sets are accepted every cycle. There are no stall outputs; the upstream array is never throttled.

Test Plan:
- Reset, then skewed single vector with shift=2, relu=0:
  - Stimulus: col0=0x0140 at t, col1=0xFF00 at t+1, col2=0x1000 at t+2.
  - Response: at t+4, empty=0, level=1, rd_data=0x7FC050 (80, -64, saturated 127).
- Same stimulus with cfg_relu=1 -> rd_data=0x7F0050. Pop it -> empty=1, rd_data=0.
- Misaligned input: in_valid=3'b111 in a single cycle, no skew -> align_err=1, level stays 0. Only clr clears align_err.
- Stream 9 aligned vectors back-to-back with DEPTH=8 and no pops -> full=1 and level=8 after the 8th, ovf=1 after the 9th. The head word is still vector 0.
- With the FIFO full, a push and rd_en in the same cycle -> level stays 8, ovf stays 0. The head becomes vector 1 and the tail is the new word.
- Saturation corners with shift=0:
  - col values 0x7FFF, 0x8000, 0x007F -> rd_data=0x7F807F.
  - Then shift=15 with 0x8000 -> byte 0xFF (-1).
  - Then assert wb_rst_i mid-stream -> all outputs return to reset values the next cycle.
